// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy rule scheduler.
// The scheduler FSM encoding and the legal range for N_SETS are defined here.
package fuzzy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam int N_SETS_MIN = 2;
    localparam int N_SETS_MAX = 8;

endpackage

// File: rtl/fuzzy_rule_scheduler_next_set_bit.sv
// Combinational search for the next set bit of a mask above a given index.
// With from_start high, the search starts below bit 0 and returns the lowest set bit.
module next_set_bit #(
    parameter int N_SETS = 3,
    parameter int IW     = $clog2(N_SETS)
) (
    input  logic [N_SETS-1:0] mask,
    input  logic [IW-1:0]     cur,
    input  logic              from_start,
    output logic [IW-1:0]     next,
    output logic              found
);

    // Scan downward so the lowest qualifying bit is the one left standing.
    always_comb begin
        next  = '0;
        found = 1'b0;
        for (int k = N_SETS - 1; k >= 0; k--) begin
            if (mask[k] && (from_start || (k > int'(cur)))) begin
                next  = IW'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fuzzy_rule_scheduler.sv
// Enumerates every active (i, j) set pair of two fuzzy inputs in row-major order
// and hands each rule to a consumer over a valid/ready interface.
module fuzzy_rule_scheduler
    import fuzzy_pkg::*;
#(
    parameter int N_SETS = 3,
    parameter int IW     = $clog2(N_SETS),
    parameter int AW     = $clog2(N_SETS * N_SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_SETS-1:0] mask_a,
    input  logic [N_SETS-1:0] mask_b,
    output logic              rule_valid,
    input  logic              rule_ready,
    output logic [IW-1:0]     rule_idx_a,
    output logic [IW-1:0]     rule_idx_b,
    output logic [AW-1:0]     rule_addr,
    output logic              rule_last,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       rule_count,
    output state_t            fsm_state
);

    // Handshake: a rule transfers on any rising edge where rule_valid and rule_ready
    // are both high; while rule_valid is high and rule_ready low, every rule output is held.

    state_t              state, state_next;
    logic [N_SETS-1:0]   mask_a_q, mask_b_q;
    logic [IW-1:0]       idx_a, idx_b, first_b;
    logic [IW-1:0]       nxt_a, nxt_b;
    logic                fnd_a, fnd_b;
    logic [AW:0]         cnt;
    logic                load, emit, accept, last;
    logic [AW-1:0]       addr;

    assign load   = (state == ST_LOAD);
    assign emit   = (state == ST_EMIT);
    assign accept = emit && rule_ready;
    assign last   = !fnd_a && !fnd_b;
    assign addr   = AW'(idx_a) * AW'(N_SETS) + AW'(idx_b);

    // In LOAD both searches return the lowest set bit; in EMIT they look above the current pair.
    next_set_bit #(.N_SETS(N_SETS), .IW(IW)) u_next_a (
        .mask(mask_a_q), .cur(idx_a), .from_start(load), .next(nxt_a), .found(fnd_a)
    );

    next_set_bit #(.N_SETS(N_SETS), .IW(IW)) u_next_b (
        .mask(mask_b_q), .cur(idx_b), .from_start(load), .next(nxt_b), .found(fnd_b)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD: state_next = (fnd_a && fnd_b) ? ST_EMIT : ST_DONE;
            ST_EMIT: if (accept && last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mask_a_q   <= '0;
            mask_b_q   <= '0;
            idx_a      <= '0;
            idx_b      <= '0;
            first_b    <= '0;
            cnt        <= '0;
            rule_count <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && start) begin
                mask_a_q <= mask_a;
                mask_b_q <= mask_b;
            end
            if (load) begin
                idx_a   <= nxt_a;
                idx_b   <= nxt_b;
                first_b <= nxt_b;
                cnt     <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
                if (fnd_b) begin
                    idx_b <= nxt_b;
                end else if (fnd_a) begin
                    idx_a <= nxt_a;
                    idx_b <= first_b;
                end
            end
            // Published on entry to DONE so it is valid alongside the done pulse.
            if (state_next == ST_DONE) rule_count <= load ? '0 : cnt + 1'b1;
        end
    end

    assign rule_valid = emit;
    assign rule_last  = emit && last;
    assign rule_idx_a = emit ? idx_a : '0;
    assign rule_idx_b = emit ? idx_b : '0;
    assign rule_addr  = emit ? addr : '0;
    assign busy       = load || emit;
    assign done       = (state == ST_DONE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_fuzzy_rule_scheduler.sv
// Directed bench for fuzzy_rule_scheduler: a table of mask pairs with hand-computed
// rule bitmaps, plus hand-written ready-stall, reset-abort and N_SETS=5 sequences.
module tb_fuzzy_rule_scheduler;
    import fuzzy_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start = 1'b0;
    logic [2:0] mask_a = '0, mask_b = '0;
    logic       rule_ready = 1'b1;
    logic       rule_valid, rule_last, busy, done;
    logic [1:0] rule_idx_a, rule_idx_b;
    logic [3:0] rule_addr;
    logic [4:0] rule_count;
    state_t     fsm_state;

    logic       start5 = 1'b0;
    logic [4:0] mask_a5 = '0, mask_b5 = '0;
    logic       rule_ready5 = 1'b1;
    logic       rule_valid5, rule_last5, busy5, done5;
    logic [2:0] rule_idx_a5, rule_idx_b5;
    logic [4:0] rule_addr5;
    logic [5:0] rule_count5;
    state_t     fsm_state5;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        logic [2:0] ma;
        logic [2:0] mb;
        logic [8:0] bm;       // bit k set = rule address k expected, emitted in ascending order
        bit         disturb;  // pulse start and change masks while rules are being emitted
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    fuzzy_rule_scheduler #(.N_SETS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .mask_a(mask_a), .mask_b(mask_b),
        .rule_valid(rule_valid), .rule_ready(rule_ready), .rule_idx_a(rule_idx_a),
        .rule_idx_b(rule_idx_b), .rule_addr(rule_addr), .rule_last(rule_last),
        .busy(busy), .done(done), .rule_count(rule_count), .fsm_state(fsm_state)
    );

    fuzzy_rule_scheduler #(.N_SETS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .mask_a(mask_a5), .mask_b(mask_b5),
        .rule_valid(rule_valid5), .rule_ready(rule_ready5), .rule_idx_a(rule_idx_a5),
        .rule_idx_b(rule_idx_b5), .rule_addr(rule_addr5), .rule_last(rule_last5),
        .busy(busy5), .done(done5), .rule_count(rule_count5), .fsm_state(fsm_state5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int k;
        logic [3:0] a;
        exp_q.delete();
        for (int i = 0; i < 9; i++) if (v.bm[i]) exp_q.push_back(4'(i));
        n = exp_q.size();
        @(negedge clk);
        rule_ready = 1'b1;
        mask_a = v.ma;
        mask_b = v.mb;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        mask_a = 3'($urandom_range(0, 7));
        mask_b = 3'($urandom_range(0, 7));
        check("load_busy", 32'(busy), 1);
        check("load_valid", 32'(rule_valid), 0);
        @(negedge clk);
        if (n == 0) begin
            check("empty_done", 32'(done), 1);
            check("empty_valid", 32'(rule_valid), 0);
            check("empty_count", 32'(rule_count), 0);
        end else begin
            k = 0;
            while (exp_q.size() > 0) begin
                a = exp_q.pop_front();
                check("rule_valid", 32'(rule_valid), 1);
                check("rule_addr", 32'(rule_addr), 32'(a));
                check("rule_idx_a", 32'(rule_idx_a), 32'(a / 3));
                check("rule_idx_b", 32'(rule_idx_b), 32'(a % 3));
                check("rule_last", 32'(rule_last), (k == n - 1) ? 1 : 0);
                check("emit_done", 32'(done), 0);
                if (v.disturb && k == 1) begin
                    start  = 1'b1;
                    mask_a = 3'b111;
                    mask_b = 3'b111;
                end else begin
                    start = 1'b0;
                end
                k++;
                @(negedge clk);
            end
            start = 1'b0;
            check("done_pulse", 32'(done), 1);
            check("done_valid", 32'(rule_valid), 0);
            check("rule_count", 32'(rule_count), 32'(n));
        end
        @(negedge clk);
        check("after_done", 32'(done), 0);
        check("after_busy", 32'(busy), 0);
        check("after_state", 32'(fsm_state), 32'(ST_IDLE));
    endtask

    initial begin
        vecs[0] = '{3'b011, 3'b110, 9'h036, 1'b0};
        vecs[1] = '{3'b000, 3'b111, 9'h000, 1'b0};
        vecs[2] = '{3'b100, 3'b100, 9'h100, 1'b0};
        vecs[3] = '{3'b111, 3'b111, 9'h1FF, 1'b0};
        vecs[4] = '{3'b101, 3'b010, 9'h082, 1'b0};
        vecs[5] = '{3'b111, 3'b000, 9'h000, 1'b0};
        vecs[6] = '{3'b010, 3'b001, 9'h008, 1'b0};
        vecs[7] = '{3'b110, 3'b101, 9'h168, 1'b0};
        vecs[8] = '{3'b011, 3'b110, 9'h036, 1'b1};

        // Reset state
        #12;
        check("rst_valid", 32'(rule_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(rule_count), 0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_state", 32'(fsm_state), 32'(ST_IDLE));

        for (int v = 0; v < 9; v++) run_vec(vecs[v]);

        // Consumer stalls three cycles on the only rule
        @(negedge clk);
        rule_ready = 1'b0;
        mask_a = 3'b100;
        mask_b = 3'b100;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(rule_valid), 1);
            check("stall_addr", 32'(rule_addr), 8);
            check("stall_last", 32'(rule_last), 1);
            check("stall_done", 32'(done), 0);
            if (c == 3) rule_ready = 1'b1;
        end
        @(negedge clk);
        check("stall_done_pulse", 32'(done), 1);
        check("stall_count", 32'(rule_count), 1);
        @(negedge clk);

        // Reset after the second accept aborts the run
        mask_a = 3'b111;
        mask_b = 3'b111;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_addr", 32'(rule_addr), 2);
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(rule_valid), 0);
        check("abort_addr", 32'(rule_addr), 0);
        check("abort_last", 32'(rule_last), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_count", 32'(rule_count), 0);
        check("abort_state", 32'(fsm_state), 32'(ST_IDLE));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 0);
        end
        rst = 1'b0;
        run_vec(vecs[0]);

        // Larger instance: all 25 pairs in order
        @(negedge clk);
        mask_a5 = 5'b11111;
        mask_b5 = 5'b11111;
        start5  = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        check("n5_load_busy", 32'(busy5), 1);
        @(negedge clk);
        for (int k = 0; k < 25; k++) begin
            check("n5_valid", 32'(rule_valid5), 1);
            check("n5_addr", 32'(rule_addr5), 32'(k));
            check("n5_idx_a", 32'(rule_idx_a5), 32'(k / 5));
            check("n5_idx_b", 32'(rule_idx_b5), 32'(k % 5));
            check("n5_last", 32'(rule_last5), (k == 24) ? 1 : 0);
            @(negedge clk);
        end
        check("n5_done", 32'(done5), 1);
        check("n5_count", 32'(rule_count5), 25);
        @(negedge clk);
        check("n5_idle", 32'(fsm_state5), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fuzzy_rule_scheduler.md
FUZZY_RULE_SCHEDULER -- requirements
Module: fuzzy_rule_scheduler

Interface
REQ-001 Parameter N_SETS, default 3: fuzzy sets per input, legal range 2..8.
REQ-002 Parameter IW, default $clog2(N_SETS): set-index width.
REQ-003 Parameter AW, default $clog2(N_SETS*N_SETS): rule-address width.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  request to enumerate one inference cycle.
REQ-007 mask_a  in  N_SETS  active-set mask of input A; bit i = set i fired.
REQ-008 mask_b  in  N_SETS  active-set mask of input B; bit j = set j fired.
REQ-009 rule_valid  out  1  rule_idx_a/b, rule_addr and rule_last are valid.
REQ-010 rule_ready  in  1  consumer accepts the current rule.
REQ-011 rule_idx_a  out  IW  set index i of the current rule.
REQ-012 rule_idx_b  out  IW  set index j of the current rule.
REQ-013 rule_addr  out  AW  rule-base address, i*N_SETS + j.
REQ-014 rule_last  out  1  current rule is the final active pair.
REQ-015 busy  out  1  high in LOAD and EMIT.
REQ-016 done  out  1  one-cycle pulse at end of enumeration.
REQ-017 rule_count  out  AW+1  number of rules emitted in the last completed run.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, EMIT, DONE.
REQ-019 IDLE: start=1 -> latch mask_a/mask_b into internal registers, go to LOAD; start=0 -> stay.
REQ-020 LOAD: either latched mask zero -> DONE; else i=lowest set bit of mask_a, j=lowest set bit of mask_b, go to EMIT.
REQ-021 EMIT SHALL hold rule_valid=1 with outputs stable until rule_valid&rule_ready.
REQ-022 Order is row-major: on accept, j advances to the next set bit of mask_b above j; if none, i advances to the next set bit of mask_a above i and j restarts at lowest set bit of mask_b.
REQ-023 rule_last=1 iff no higher set bit exists in mask_b above j and none in mask_a above i.
REQ-024 Accept with rule_last=1 -> DONE; DONE asserts done for one cycle, updates rule_count, returns to IDLE.
REQ-025 Latency: start in cycle t -> first rule_valid in cycle t+2; with rule_ready held high one rule per cycle, done one cycle after the last accept.
REQ-026 start outside IDLE SHALL be ignored; mask inputs outside IDLE SHALL be ignored (latched copy used).
REQ-027 Internal emitted-rule counter SHALL clear in LOAD, increment per accept, never wrap (max N_SETS*N_SETS fits AW+1).
REQ-028 rule_valid, rule_last, rule_idx_a/b, rule_addr SHALL be 0 outside EMIT.

Reset
REQ-029 rst SHALL immediately force IDLE; rule_valid, rule_last, busy, done=0; rule_idx_a/b, rule_addr, rule_count, latched masks=0.
REQ-030 rst during EMIT SHALL abort the run with no done pulse; rule_count keeps 0.

Structure
REQ-031 Package fuzzy_pkg SHALL hold the state enum typedef and the N_SETS legal-range constants.
REQ-032 One sub-module next_set_bit (combinational: mask, current index -> next higher set index, found flag) SHALL be instantiated twice (A and B); lowest-bit search uses it with a start-below-0 flag.

Verification
REQ-033 N_SETS=3, mask_a=011, mask_b=110, ready=1 -> addrs 1,2,4,5; (i,j)=(0,1),(0,2),(1,1),(1,2); rule_last on 4th; done next cycle; rule_count=4.
REQ-034 mask_a=000, mask_b=111, start -> no rule_valid; done in cycle t+2; rule_count=0.
REQ-035 mask_a=100, mask_b=100, ready low 3 cycles -> addr 8 held stable 4 cycles, single accept, rule_last=1.
REQ-036 start pulsed and masks changed mid-EMIT -> sequence unchanged from originally latched masks; no restart.
REQ-037 rst asserted after 2nd accept -> all outputs 0 same cycle, no done, next start enumerates from first pair.
REQ-038 N_SETS=5, masks 11111/11111 -> addrs 0..24 in order, rule_count=25.
